// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK multi-channel 2D convolution with stride and saturation
//
// Purpose: accepts one pixel per beat in raster order, keeps FILTERHEIGHT-1 previous
// rows in line buffers plus a KxK window register, and emits one FILTERBATCH-wide
// saturated convolution result per valid (strided) window position.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     pixel handshake; in_pixel carries channel 0 in the MSBs
//   filterWeight          batch, channel, row, col order; first element in the MSBs
//   filterBias            one bias per filter; batch 0 in the MSBs
//   wload                 latch filterWeight/filterBias into internal registers
//   out_valid/out_ready   result handshake; result carries batch 0 in the MSBs
//   out_last              set with the result of the last window of a frame
module conv2d_stream #(
  parameter int BITWIDTH     = 8,
  parameter int DATAWIDTH    = 4,
  parameter int DATAHEIGHT   = 4,
  parameter int DATACHANNEL  = 1,
  parameter int FILTERHEIGHT = 3,
  parameter int FILTERWIDTH  = 3,
  parameter int FILTERBATCH  = 1,
  parameter int STRIDEHEIGHT = 1,
  parameter int STRIDEWIDTH  = 1
) (
  input  logic                                                                clk,
  input  logic                                                                reset,
  input  logic                                                                in_valid,
  output logic                                                                in_ready,
  input  logic [DATACHANNEL*BITWIDTH-1:0]                                     in_pixel,
  input  logic [FILTERBATCH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH*BITWIDTH-1:0] filterWeight,
  input  logic [FILTERBATCH*BITWIDTH-1:0]                                     filterBias,
  input  logic                                                                wload,
  output logic                                                                out_valid,
  input  logic                                                                out_ready,
  output logic [FILTERBATCH*2*BITWIDTH-1:0]                                   result,
  output logic                                                                out_last
);

  localparam int PW   = DATACHANNEL * BITWIDTH;
  localparam int NTAP = DATACHANNEL * FILTERHEIGHT * FILTERWIDTH;
  localparam int NW   = FILTERBATCH * NTAP;
  localparam int OW   = 2 * BITWIDTH;
  localparam int ACCW = OW + $clog2(NTAP) + 1;
  localparam int CW   = $clog2(DATAWIDTH);
  localparam int RW   = $clog2(DATAHEIGHT);
  localparam int OUTW = (DATAWIDTH - FILTERWIDTH) / STRIDEWIDTH + 1;
  localparam int OUTH = (DATAHEIGHT - FILTERHEIGHT) / STRIDEHEIGHT + 1;

  localparam logic [31:0] FW1    = 32'(FILTERWIDTH - 1);
  localparam logic [31:0] FH1    = 32'(FILTERHEIGHT - 1);
  localparam logic [31:0] SW32   = 32'(STRIDEWIDTH);
  localparam logic [31:0] SH32   = 32'(STRIDEHEIGHT);
  localparam logic [31:0] LAST_C = 32'(FILTERWIDTH - 1 + (OUTW - 1) * STRIDEWIDTH);
  localparam logic [31:0] LAST_R = 32'(FILTERHEIGHT - 1 + (OUTH - 1) * STRIDEHEIGHT);

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic [NW*BITWIDTH-1:0]          wreg;
  logic [FILTERBATCH*BITWIDTH-1:0] breg;

  // lbuf[0] holds the previous row, lbuf[k] the row k+1 above the current one
  logic [PW-1:0] lbuf [FILTERHEIGHT-1][DATAWIDTH];
  logic [PW-1:0] win  [FILTERHEIGHT][FILTERWIDTH];
  logic [PW-1:0] nwin [FILTERHEIGHT][FILTERWIDTH];

  logic        accept;
  logic        win_valid;
  logic        is_last;
  logic [31:0] col_w;
  logic [31:0] row_w;

  logic signed [BITWIDTH-1:0] ps;
  logic signed [BITWIDTH-1:0] ws;
  logic signed [BITWIDTH-1:0] bs;
  logic signed [OW-1:0]       prod;
  logic signed [ACCW-1:0]     acc;
  logic [FILTERBATCH*OW-1:0]  sat_res;

  // Single output register: a new pixel may enter whenever the output slot is free
  // or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    col_w     = 32'(col_q);
    row_w     = 32'(row_q);
    win_valid = (col_w >= FW1) && (((col_w - FW1) % SW32) == 32'd0) &&
                (row_w >= FH1) && (((row_w - FH1) % SH32) == 32'd0);
    is_last   = (col_w == LAST_C) && (row_w == LAST_R);
  end

  // Window as it will be after the current pixel is shifted in; the result is
  // computed from this so it can be registered on the accepting edge.
  always_comb begin
    for (int i = 0; i < FILTERHEIGHT; i++) begin
      for (int j = 0; j < FILTERWIDTH - 1; j++) begin
        nwin[i][j] = win[i][j+1];
      end
    end
    for (int i = 0; i < FILTERHEIGHT - 1; i++) begin
      nwin[i][FILTERWIDTH-1] = lbuf[FILTERHEIGHT-2-i][col_q];
    end
    nwin[FILTERHEIGHT-1][FILTERWIDTH-1] = in_pixel;
  end

  always_comb begin
    ps      = '0;
    ws      = '0;
    bs      = '0;
    prod    = '0;
    acc     = '0;
    sat_res = '0;
    for (int b = 0; b < FILTERBATCH; b++) begin
      bs  = breg[(FILTERBATCH-1-b)*BITWIDTH +: BITWIDTH];
      acc = ACCW'(bs);
      for (int ch = 0; ch < DATACHANNEL; ch++) begin
        for (int i = 0; i < FILTERHEIGHT; i++) begin
          for (int j = 0; j < FILTERWIDTH; j++) begin
            ps   = nwin[i][j][(DATACHANNEL-1-ch)*BITWIDTH +: BITWIDTH];
            ws   = wreg[(NW-1-(((b*DATACHANNEL+ch)*FILTERHEIGHT+i)*FILTERWIDTH+j))*BITWIDTH +: BITWIDTH];
            prod = OW'(ps) * OW'(ws);
            acc  = acc + ACCW'(prod);
          end
        end
      end
      if (acc > SAT_MAX) begin
        sat_res[(FILTERBATCH-1-b)*OW +: OW] = {1'b0, {(OW-1){1'b1}}};
      end else if (acc < SAT_MIN) begin
        sat_res[(FILTERBATCH-1-b)*OW +: OW] = {1'b1, {(OW-1){1'b0}}};
      end else begin
        sat_res[(FILTERBATCH-1-b)*OW +: OW] = acc[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      wreg      <= '0;
      breg      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      result    <= '0;
    end else begin
      if (wload) begin
        wreg <= filterWeight;
        breg <= filterBias;
      end
      if (accept) begin
        if (col_q == CW'(DATAWIDTH - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(DATAHEIGHT - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (accept && win_valid) begin
        result    <= sat_res;
        out_valid <= 1'b1;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Line buffers and window are not reset: the counter restart makes their
  // contents irrelevant until they are refilled.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      win <= nwin;
      lbuf[0][col_q] <= in_pixel;
      for (int k = 1; k < FILTERHEIGHT - 1; k++) begin
        lbuf[k][col_q] <= lbuf[k-1][col_q];
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - directed self-checking bench for conv2d_stream
module tb_conv2d_stream;

  logic clk;
  logic reset;

  logic        iv_a, ir_a, wl_a, ov_a, or_a, ol_a;
  logic [7:0]  px_a;
  logic [71:0] wt_a;
  logic [7:0]  bi_a;
  logic [15:0] res_a;

  logic        iv_b, ir_b, wl_b, ov_b, or_b, ol_b;
  logic [7:0]  px_b;
  logic [71:0] wt_b;
  logic [7:0]  bi_b;
  logic [15:0] res_b;

  logic         iv_c, ir_c, wl_c, ov_c, or_c, ol_c;
  logic [7:0]   px_c;
  logic [143:0] wt_c;
  logic [15:0]  bi_c;
  logic [31:0]  res_c;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] qc[$];
  logic [32:0] ex[$];

  int err_cnt = 0;
  int chk_cnt = 0;

  conv2d_stream u_a (
    .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .in_pixel(px_a),
    .filterWeight(wt_a), .filterBias(bi_a), .wload(wl_a), .out_valid(ov_a),
    .out_ready(or_a), .result(res_a), .out_last(ol_a)
  );

  conv2d_stream #(.DATAWIDTH(5), .DATAHEIGHT(5), .STRIDEHEIGHT(2), .STRIDEWIDTH(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .in_pixel(px_b),
    .filterWeight(wt_b), .filterBias(bi_b), .wload(wl_b), .out_valid(ov_b),
    .out_ready(or_b), .result(res_b), .out_last(ol_b)
  );

  conv2d_stream #(.FILTERBATCH(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(iv_c), .in_ready(ir_c), .in_pixel(px_c),
    .filterWeight(wt_c), .filterBias(bi_c), .wload(wl_c), .out_valid(ov_c),
    .out_ready(or_c), .result(res_c), .out_last(ol_c)
  );

  always #5 clk = ~clk;

  // Record every completed output transfer as {last, result}
  always @(negedge clk) begin
    if (!reset) begin
      if (ov_a && or_a) qa.push_back({ol_a, 16'h0, res_a});
      if (ov_b && or_b) qb.push_back({ol_b, 16'h0, res_b});
      if (ov_c && or_c) qc.push_back({ol_c, res_c});
    end
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [32:0] q[$], input logic [32:0] e[$]);
    check({tag, "_count"}, 40'(q.size()), 40'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), (i < q.size()) ? 40'(q[i]) : 40'hEE_EEEE_EEEE, 40'(e[i]));
    end
  endtask

  task automatic send(input int u, input logic [7:0] p);
    logic rdy;
    bit   done;
    done = 0;
    case (u)
      0: begin iv_a = 1'b1; px_a = p; end
      1: begin iv_b = 1'b1; px_b = p; end
      default: begin iv_c = 1'b1; px_c = p; end
    endcase
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      rdy = (u == 0) ? ir_a : (u == 1) ? ir_b : ir_c;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
    end
    if (!done) check("send_timeout", 40'd0, 40'd1);
  endtask

  task automatic idle(input int u);
    case (u)
      0: iv_a = 1'b0;
      1: iv_b = 1'b0;
      default: iv_c = 1'b0;
    endcase
  endtask

  task automatic frame(input int u, input int n, input bit konst, input logic [7:0] val);
    for (int i = 0; i < n; i++) send(u, konst ? val : 8'(i + 1));
  endtask

  task automatic load(input int u, input logic [143:0] wt, input logic [15:0] bi);
    case (u)
      0: begin wt_a = wt[71:0]; bi_a = bi[7:0]; wl_a = 1'b1; end
      1: begin wt_b = wt[71:0]; bi_b = bi[7:0]; wl_b = 1'b1; end
      default: begin wt_c = wt; bi_c = bi; wl_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    wl_a = 1'b0; wl_b = 1'b0; wl_c = 1'b0;
  endtask

  function automatic logic [32:0] e1(input logic l, input logic [31:0] v);
    return {l, v};
  endfunction

  initial begin
    bit seen;
    clk = 0; reset = 1;
    iv_a = 0; px_a = 0; wt_a = 0; bi_a = 0; wl_a = 0; or_a = 1;
    iv_b = 0; px_b = 0; wt_b = 0; bi_b = 0; wl_b = 0; or_b = 1;
    iv_c = 0; px_c = 0; wt_c = 0; bi_c = 0; wl_c = 0; or_c = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 40'(ir_a), 40'd1);
    check("rst_out_valid", 40'(ov_a), 40'd0);
    check("rst_result", 40'(res_a), 40'd0);
    check("rst_out_last", 40'(ol_a), 40'd0);
    reset = 0;

    // Test 1: all-ones 3x3 kernel over 4x4 ramp
    load(0, {72'h0, {9{8'h01}}}, 16'h0000);
    qa.delete();
    for (int i = 1; i <= 10; i++) send(0, 8'(i));
    check("t1_pre_valid", 40'(ov_a), 40'd0);
    send(0, 8'd11);
    check("t1_lat_valid", 40'(ov_a), 40'd1);
    check("t1_lat_result", 40'(res_a), 40'h0036);
    for (int i = 12; i <= 16; i++) send(0, 8'(i));
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    ex = {e1(0, 32'h36), e1(0, 32'h3F), e1(0, 32'h5A), e1(1, 32'h63)};
    check_q("t1", qa, ex);

    // Test 4: backpressure from the first result
    qa.delete();
    or_a = 1'b0;
    fork
      begin
        frame(0, 16, 0, 8'h00);
        idle(0);
      end
      begin
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge clk);
          if (ov_a) seen = 1;
        end
        check("t4_seen_valid", 40'(seen), 40'd1);
        check("t4_hold_res0", 40'(res_a), 40'h0036);
        check("t4_in_ready0", 40'(ir_a), 40'd0);
        repeat (8) @(negedge clk);
        check("t4_hold_res1", 40'(res_a), 40'h0036);
        check("t4_hold_valid", 40'(ov_a), 40'd1);
        check("t4_in_ready1", 40'(ir_a), 40'd0);
        @(posedge clk);
        #1;
        or_a = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check_q("t4", qa, ex);

    // Test 5: reset in the middle of a frame
    frame(0, 7, 0, 8'h00);
    idle(0);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    check("t5_out_valid", 40'(ov_a), 40'd0);
    check("t5_in_ready", 40'(ir_a), 40'd1);
    qa.delete();
    load(0, {72'h0, {9{8'h01}}}, 16'h0000);
    frame(0, 16, 0, 8'h00);
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    check_q("t5", qa, ex);

    // Test 3: positive and negative saturation
    load(0, {72'h0, {9{8'h7F}}}, 16'h0000);
    qa.delete();
    frame(0, 16, 1, 8'h7F);
    frame(0, 16, 1, 8'h80);
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    ex = {e1(0, 32'h7FFF), e1(0, 32'h7FFF), e1(0, 32'h7FFF), e1(1, 32'h7FFF),
          e1(0, 32'h8000), e1(0, 32'h8000), e1(0, 32'h8000), e1(1, 32'h8000)};
    check_q("t3", qa, ex);

    // Test 2: 5x5 image, stride 2
    load(1, {72'h0, {9{8'h01}}}, 16'h0000);
    qb.delete();
    frame(1, 25, 0, 8'h00);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    ex = {e1(0, 32'd63), e1(0, 32'd81), e1(0, 32'd153), e1(1, 32'd171)};
    check_q("t2", qb, ex);

    // Test 6: two filters with biases +1/-1, two back-to-back frames
    load(2, {18{8'h01}}, 16'h01FF);
    qc.delete();
    frame(2, 16, 0, 8'h00);
    frame(2, 16, 0, 8'h00);
    idle(2);
    repeat (3) @(posedge clk);
    #1;
    ex = {e1(0, 32'h0037_0035), e1(0, 32'h0040_003E), e1(0, 32'h005B_0059), e1(1, 32'h0064_0062),
          e1(0, 32'h0037_0035), e1(0, 32'h0040_003E), e1(0, 32'h005B_0059), e1(1, 32'h0064_0062)};
    check_q("t6", qc, ex);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
